// File: rtl/tcdm_bank_responder_pkg.sv
// Shared types and helpers for the TCDM bank responder.
package tcdm_bank_responder_pkg;

    // Data returned for anything that is not a banked read (writes and out-of-range accesses)
    localparam logic [31:0] TCDM_OOR_RDATA = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] add;
        logic        wen;
        logic [3:0]  be;
        logic [31:0] data;
    } tcdm_req_t;

    typedef struct packed {
        logic [31:0] r_data;
        logic        r_valid;
    } tcdm_rsp_t;

    function automatic int BANK_IDX_W(input int nb);
        return (nb > 1) ? $clog2(nb) : 1;
    endfunction

endpackage

// File: rtl/tcdm_bank_responder_if.sv
// TCDM master-port bundle: MP request channels with same-cycle grant and 1-cycle response.
interface tcdm_bank_responder_if #(parameter int MP = 5) ();
    logic [MP-1:0]       tcdm_req;
    logic [MP-1:0]       tcdm_gnt;
    logic [MP-1:0][31:0] tcdm_add;
    logic [MP-1:0]       tcdm_wen;
    logic [MP-1:0][3:0]  tcdm_be;
    logic [MP-1:0][31:0] tcdm_data;
    logic [MP-1:0][31:0] tcdm_r_data;
    logic [MP-1:0]       tcdm_r_valid;

    modport master (
        output tcdm_req, tcdm_add, tcdm_wen, tcdm_be, tcdm_data,
        input  tcdm_gnt, tcdm_r_data, tcdm_r_valid
    );

    modport slave (
        input  tcdm_req, tcdm_add, tcdm_wen, tcdm_be, tcdm_data,
        output tcdm_gnt, tcdm_r_data, tcdm_r_valid
    );
endinterface

// File: rtl/tcdm_bank_responder_rr_arbiter.sv
// Round-robin arbiter for one bank: search starts at the pointer, pointer moves past the winner.
module tcdm_rr_arbiter #(
    parameter int N = 5
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [N-1:0] i_req,
    input  logic         i_adv,
    output logic [N-1:0] o_gnt
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_win;
    logic [PW-1:0] w_idx;
    logic [PW:0]   w_sum;
    logic          w_found;

    always_comb begin
        o_gnt   = '0;
        w_win   = '0;
        w_idx   = '0;
        w_sum   = '0;
        w_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            w_sum = {1'b0, r_ptr} + (PW+1)'(i);
            if (w_sum >= (PW+1)'(N)) w_sum = w_sum - (PW+1)'(N);
            w_idx = w_sum[PW-1:0];
            if (!w_found && i_req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
        if (w_found) o_gnt[w_win] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_ptr <= '0;
        else if (i_adv && w_found)
            r_ptr <= (w_win == PW'(N-1)) ? '0 : w_win + 1'b1;
    end
endmodule

// File: rtl/tcdm_bank_responder.sv
// Word-interleaved multi-bank TCDM slave: per-bank RR arbitration, fixed 1-cycle response,
// out-of-range accesses granted immediately, conflict and out-of-range counters.
module tcdm_bank_responder
    import tcdm_bank_responder_pkg::*;
#(
    parameter int          MP         = 5,
    parameter int          NB         = 8,
    parameter int          BANK_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    tcdm_bank_responder_if.slave tcdm,
    output logic [31:0]          conflict_cnt_o,
    output logic [15:0]          oor_cnt_o
);
    localparam int          BW   = BANK_IDX_W(NB);
    localparam int          RW   = (BANK_WORDS > 1) ? $clog2(BANK_WORDS) : 1;
    localparam logic [32:0] SPAN = 33'(NB) * 33'(BANK_WORDS) * 33'd4;

    tcdm_req_t [MP-1:0]          w_req;
    tcdm_rsp_t [MP-1:0]          w_rsp;
    logic      [MP-1:0][31:0]    w_off;
    logic      [MP-1:0]          w_inr;
    logic      [MP-1:0][BW-1:0]  w_bank;
    logic      [MP-1:0][RW-1:0]  w_row;
    logic      [NB-1:0][MP-1:0]  w_bgnt;
    logic      [NB-1:0][31:0]    w_brdata;
    logic      [MP-1:0]          w_gnt;
    logic      [MP-1:0]          w_oor_gnt;
    logic      [16:0]            w_oor_sum;

    logic      [MP-1:0]          r_valid;
    logic      [MP-1:0]          r_isrd;
    logic      [MP-1:0][BW-1:0]  r_bank;
    logic      [MP-1:0][31:0]    r_hold;
    logic      [31:0]            r_conf;
    logic      [15:0]            r_oor;

    // Address decode; the 33-bit compare keeps a full 4 GiB span from overflowing
    always_comb begin
        for (int p = 0; p < MP; p++) begin
            w_req[p].add  = tcdm.tcdm_add[p];
            w_req[p].wen  = tcdm.tcdm_wen[p];
            w_req[p].be   = tcdm.tcdm_be[p];
            w_req[p].data = tcdm.tcdm_data[p];
            w_off[p]      = w_req[p].add - BASE_ADDR;
            w_inr[p]      = (w_req[p].add >= BASE_ADDR) && ({1'b0, w_off[p]} < SPAN);
            w_bank[p]     = w_off[p][2 +: BW];
            w_row[p]      = w_off[p][2+BW +: RW];
        end
    end

    for (genvar b = 0; b < NB; b++) begin : g_bank
        logic [MP-1:0] w_breq;
        logic [RW-1:0] w_srow;
        logic          w_swen;
        logic [3:0]    w_sbe;
        logic [31:0]   w_sdata;
        logic [31:0]   r_mem [BANK_WORDS];
        logic [31:0]   r_rdata;

        always_comb begin
            w_breq = '0;
            for (int p = 0; p < MP; p++)
                w_breq[p] = tcdm.tcdm_req[p] && w_inr[p] && (w_bank[p] == BW'(b));
        end

        tcdm_rr_arbiter #(.N(MP)) u_arb (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .i_req  (w_breq),
            .i_adv  (|w_breq),
            .o_gnt  (w_bgnt[b])
        );

        always_comb begin
            w_srow  = '0;
            w_swen  = 1'b1;
            w_sbe   = '0;
            w_sdata = '0;
            for (int p = 0; p < MP; p++) begin
                if (w_bgnt[b][p]) begin
                    w_srow  = w_row[p];
                    w_swen  = w_req[p].wen;
                    w_sbe   = w_req[p].be;
                    w_sdata = w_req[p].data;
                end
            end
        end

        // Storage is deliberately not reset so it survives a mid-run reset
        always_ff @(posedge clk_i) begin
            if (|w_bgnt[b]) begin
                if (w_swen)
                    r_rdata <= r_mem[w_srow];
                else
                    for (int i = 0; i < 4; i++)
                        if (w_sbe[i]) r_mem[w_srow][8*i +: 8] <= w_sdata[8*i +: 8];
            end
        end

        assign w_brdata[b] = r_rdata;
    end

    assign w_oor_gnt = tcdm.tcdm_req & ~w_inr;

    always_comb begin
        w_gnt = w_oor_gnt;
        for (int b = 0; b < NB; b++) w_gnt = w_gnt | w_bgnt[b];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= '0;
            r_isrd  <= '0;
            r_bank  <= '0;
            r_hold  <= '0;
        end else begin
            r_valid <= w_gnt;
            for (int p = 0; p < MP; p++) begin
                if (w_gnt[p]) begin
                    r_isrd[p] <= w_req[p].wen && w_inr[p];
                    r_bank[p] <= w_bank[p];
                end
                if (r_valid[p]) r_hold[p] <= w_rsp[p].r_data;
            end
        end
    end

    // Response data comes straight from the bank read register; r_hold keeps it stable afterwards
    always_comb begin
        for (int p = 0; p < MP; p++) begin
            w_rsp[p].r_valid = r_valid[p];
            if (!r_valid[p])
                w_rsp[p].r_data = r_hold[p];
            else if (r_isrd[p])
                w_rsp[p].r_data = w_brdata[r_bank[p]];
            else
                w_rsp[p].r_data = TCDM_OOR_RDATA;
            tcdm.tcdm_r_valid[p] = w_rsp[p].r_valid;
            tcdm.tcdm_r_data[p]  = w_rsp[p].r_data;
        end
    end

    assign tcdm.tcdm_gnt = w_gnt;

    always_comb begin
        w_oor_sum = {1'b0, r_oor};
        for (int p = 0; p < MP; p++) w_oor_sum = w_oor_sum + 17'(w_oor_gnt[p]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_conf <= '0;
            r_oor  <= '0;
        end else begin
            if (|(tcdm.tcdm_req & ~w_gnt) && (r_conf != 32'hFFFF_FFFF))
                r_conf <= r_conf + 32'd1;
            r_oor <= w_oor_sum[16] ? 16'hFFFF : w_oor_sum[15:0];
        end
    end

    assign conflict_cnt_o = r_conf;
    assign oor_cnt_o      = r_oor;
endmodule
